// File: rtl/pill_feeder_if.sv
// Signal bundle between the pill feeder and the bottle-counting side.
// The feeder uses the slave modport; the counting FSM or bench uses master.
interface pill_feeder_if;
    logic       run_en;
    logic       bottle_full;
    logic       hopper_stop;
    logic       hopper_add;
    logic       conveyor_stop;
    logic       estop;
    logic       fault_clr;
    logic       pill_pulse;
    logic [7:0] hopper_level;
    logic       hopper_low;
    logic       feeding;
    logic       conveyor_busy;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output run_en, bottle_full, hopper_stop, hopper_add, conveyor_stop, estop, fault_clr,
        input  pill_pulse, hopper_level, hopper_low, feeding, conveyor_busy, fault, fault_code
    );

    modport slave (
        input  run_en, bottle_full, hopper_stop, hopper_add, conveyor_stop, estop, fault_clr,
        output pill_pulse, hopper_level, hopper_low, feeding, conveyor_busy, fault, fault_code
    );
endinterface

// File: rtl/pill_feeder_ctrl.sv
// Hopper/conveyor feed stage: paced pill pulses, hopper level, conveyor indexing, faults.
// Optional build macro PILL_JITTER_EN adds LFSR-based jitter to the pill spacing.
module pill_feeder_ctrl #(
    parameter int FEED_PERIOD   = 250,
    parameter int HOPPER_CAP    = 200,
    parameter int REFILL_STEP   = 50,
    parameter int LOW_LEVEL     = 20,
    parameter int CHANGE_CYCLES = 1000,
    parameter int STALL_TIMEOUT = 3000
) (
    input  logic         clk_1khz,
    input  logic         switch_clr,
    pill_feeder_if.slave bus
);
    // Pace is widened by 32 so the jittered terminal count always fits.
    localparam int PACE_W  = $clog2(FEED_PERIOD + 32);
    localparam int CHG_W   = $clog2(CHANGE_CYCLES);
    localparam int STALL_W = $clog2(STALL_TIMEOUT);

    localparam logic [CHG_W-1:0]   CHG_LAST   = CHG_W'(CHANGE_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);
    localparam logic [7:0]         CAP_LVL    = 8'(HOPPER_CAP);
    localparam logic [7:0]         LOW_LVL    = 8'(LOW_LEVEL);

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ESTOP   = 2'd1;
    localparam logic [1:0] FC_JAM     = 2'd2;
    localparam logic [1:0] FC_STARVED = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FEED   = 3'd1,
        ST_CHANGE = 3'd2,
        ST_STALL  = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    // Next hopper level: optional decrement, optional refill, saturate at capacity.
    function automatic logic [7:0] next_level(input logic [7:0] level, input logic dec, input logic add);
        logic [8:0] sum;
        sum = {1'b0, level} - {8'd0, dec} + (add ? 9'(REFILL_STEP) : 9'd0);
        if (sum > {1'b0, CAP_LVL}) begin
            next_level = CAP_LVL;
        end else begin
            next_level = sum[7:0];
        end
    endfunction

    state_t              state_r, state_n;
    logic [PACE_W-1:0]   pace_r, pace_n, pace_term_s;
    logic [CHG_W-1:0]    chg_r, chg_n;
    logic [STALL_W-1:0]  stall_r, stall_n;
    logic [1:0]          code_r, code_n;
    logic [7:0]          hopper_level_r, level_n;
    logic                pill_s;
    logic                pill_pulse_r, feeding_r, conveyor_busy_r, fault_r, hopper_low_r;
    logic [1:0]          add_sync_r, clr_sync_r;
    logic                add_prev_r, clr_prev_r;
    logic                add_rise_s, clr_rise_s;

    // Two-flop synchronisers and rising-edge history for the raw buttons.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            add_sync_r <= 2'b00;
            clr_sync_r <= 2'b00;
            add_prev_r <= 1'b0;
            clr_prev_r <= 1'b0;
        end else begin
            add_sync_r <= {add_sync_r[0], bus.hopper_add};
            clr_sync_r <= {clr_sync_r[0], bus.fault_clr};
            add_prev_r <= add_sync_r[1];
            clr_prev_r <= clr_sync_r[1];
        end
    end

    assign add_rise_s = add_sync_r[1] & ~add_prev_r;
    assign clr_rise_s = clr_sync_r[1] & ~clr_prev_r;

`ifdef PILL_JITTER_EN
    logic [7:0] lfsr_r;

    // Fibonacci LFSR (taps 8,6,5,4) stepped once per dispensed pill.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            lfsr_r <= 8'hA5;
        end else if (pill_s) begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign pace_term_s = PACE_W'(FEED_PERIOD - 32) + PACE_W'(lfsr_r[5:0]);
`else
    assign pace_term_s = PACE_W'(FEED_PERIOD - 1);
`endif

    // Next-state logic; estop outranks every other transition outside FAULT.
    always_comb begin
        state_n = state_r;
        pace_n  = pace_r;
        chg_n   = chg_r;
        stall_n = stall_r;
        code_n  = code_r;
        pill_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pace_n  = {PACE_W{1'b0}};
                chg_n   = {CHG_W{1'b0}};
                stall_n = {STALL_W{1'b0}};
                if (bus.estop) begin
                    state_n = ST_FAULT;
                    code_n  = FC_ESTOP;
                end else if (bus.run_en) begin
                    state_n = ST_FEED;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (bus.estop) begin
                    state_n = ST_FAULT;
                    code_n  = FC_ESTOP;
                end else if (bus.bottle_full) begin
                    state_n = ST_CHANGE;
                    pace_n  = {PACE_W{1'b0}};
                    chg_n   = {CHG_W{1'b0}};
                end else if (!bus.run_en) begin
                    state_n = ST_IDLE;
                    pace_n  = {PACE_W{1'b0}};
                end else if (bus.hopper_stop) begin
                    pace_n = pace_r;
                end else if (pace_r == pace_term_s) begin
                    pace_n = {PACE_W{1'b0}};
                    if (hopper_level_r != 8'd0) begin
                        pill_s = 1'b1;
                    end else begin
                        state_n = ST_STALL;
                        stall_n = {STALL_W{1'b0}};
                    end
                end else begin
                    pace_n = pace_r + PACE_W'(1);
                end
            end
            ST_CHANGE: begin
                if (bus.estop) begin
                    state_n = ST_FAULT;
                    code_n  = FC_ESTOP;
                end else if (bus.conveyor_stop) begin
                    state_n = ST_FAULT;
                    code_n  = FC_JAM;
                end else if (chg_r == CHG_LAST) begin
                    chg_n   = {CHG_W{1'b0}};
                    pace_n  = {PACE_W{1'b0}};
                    state_n = bus.run_en ? ST_FEED : ST_IDLE;
                end else begin
                    chg_n = chg_r + CHG_W'(1);
                end
            end
            ST_STALL: begin
                if (bus.estop) begin
                    state_n = ST_FAULT;
                    code_n  = FC_ESTOP;
                end else if (!bus.run_en) begin
                    state_n = ST_IDLE;
                end else if (hopper_level_r != 8'd0) begin
                    state_n = ST_FEED;
                    pace_n  = {PACE_W{1'b0}};
                    stall_n = {STALL_W{1'b0}};
                end else if (stall_r == STALL_LAST) begin
                    state_n = ST_FAULT;
                    code_n  = FC_STARVED;
                end else begin
                    stall_n = stall_r + STALL_W'(1);
                end
            end
            ST_FAULT: begin
                // A clear edge seen while estop or jam persists is simply lost.
                if (clr_rise_s && !bus.estop && !bus.conveyor_stop) begin
                    state_n = ST_IDLE;
                    code_n  = FC_NONE;
                end else begin
                    state_n = ST_FAULT;
                end
            end
            default: begin
                state_n = ST_IDLE;
                code_n  = FC_NONE;
            end
        endcase
        level_n = next_level(hopper_level_r, pill_s, add_rise_s);
    end

    // State, counters, hopper level and registered status outputs.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state_r         <= ST_IDLE;
            pace_r          <= {PACE_W{1'b0}};
            chg_r           <= {CHG_W{1'b0}};
            stall_r         <= {STALL_W{1'b0}};
            code_r          <= FC_NONE;
            hopper_level_r  <= CAP_LVL;
            pill_pulse_r    <= 1'b0;
            feeding_r       <= 1'b0;
            conveyor_busy_r <= 1'b0;
            fault_r         <= 1'b0;
            hopper_low_r    <= 1'b0;
        end else begin
            state_r         <= state_n;
            pace_r          <= pace_n;
            chg_r           <= chg_n;
            stall_r         <= stall_n;
            code_r          <= code_n;
            hopper_level_r  <= level_n;
            pill_pulse_r    <= pill_s;
            feeding_r       <= (state_n == ST_FEED);
            conveyor_busy_r <= (state_n == ST_CHANGE);
            fault_r         <= (state_n == ST_FAULT);
            hopper_low_r    <= (level_n <= LOW_LVL);
        end
    end

    assign bus.pill_pulse    = pill_pulse_r;
    assign bus.hopper_level  = hopper_level_r;
    assign bus.hopper_low    = hopper_low_r;
    assign bus.feeding       = feeding_r;
    assign bus.conveyor_busy = conveyor_busy_r;
    assign bus.fault         = fault_r;
    assign bus.fault_code    = code_r;
endmodule

// File: tb/tb_pill_feeder_ctrl.sv
// Directed bench for pill_feeder_ctrl at default parameters, jitter disabled.
module tb_pill_feeder_ctrl;
    logic clk_1khz;
    logic switch_clr;
    int   n_checks;
    int   n_fail;
    int   pulses;
    int   first_k;
    int   last_k;
    int   busy_cnt;

    pill_feeder_if bus ();

    pill_feeder_ctrl dut (
        .clk_1khz   (clk_1khz),
        .switch_clr (switch_clr),
        .bus        (bus)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles (sampling on falling edges), counting pulses and busy cycles.
    task automatic run_cycles(input int n, output int p, output int fk, output int lk, output int bc);
        p = 0; fk = 0; lk = 0; bc = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_1khz);
            if (bus.pill_pulse) begin
                p++;
                if (fk == 0) fk = k;
                lk = k;
            end
            if (bus.conveyor_busy) bc++;
        end
    endtask

    task automatic press_add();
        bus.hopper_add = 1'b1;
        repeat (4) @(negedge clk_1khz);
        bus.hopper_add = 1'b0;
        repeat (2) @(negedge clk_1khz);
    endtask

    task automatic press_clr();
        bus.fault_clr = 1'b1;
        repeat (4) @(negedge clk_1khz);
        bus.fault_clr = 1'b0;
        repeat (2) @(negedge clk_1khz);
    endtask

    task automatic pulse_bottle_full();
        bus.bottle_full = 1'b1;
        @(negedge clk_1khz);
        bus.bottle_full = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        switch_clr        = 1'b0;
        bus.run_en        = 1'b0;
        bus.bottle_full   = 1'b0;
        bus.hopper_stop   = 1'b0;
        bus.hopper_add    = 1'b0;
        bus.conveyor_stop = 1'b0;
        bus.estop         = 1'b0;
        bus.fault_clr     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_1khz);
        check_eq("rst_level", 32'(bus.hopper_level), 32'd200);
        check_eq("rst_low", 32'(bus.hopper_low), 32'd0);
        check_eq("rst_fault", 32'(bus.fault), 32'd0);
        check_eq("rst_code", 32'(bus.fault_code), 32'd0);
        check_eq("rst_feeding", 32'(bus.feeding), 32'd0);
        check_eq("rst_pulse", 32'(bus.pill_pulse), 32'd0);
        switch_clr = 1'b1;
        run_cycles(5, pulses, first_k, last_k, busy_cnt);
        check_eq("idle_feeding", 32'(bus.feeding), 32'd0);

        // Normal pacing: pulses 250, 500, 750, 1000 cycles after FEED entry
        bus.run_en = 1'b1;
        @(negedge clk_1khz);
        check_eq("feed_entry", 32'(bus.feeding), 32'd1);
        run_cycles(1000, pulses, first_k, last_k, busy_cnt);
        check_eq("pace_count", 32'(pulses), 32'd4);
        check_eq("pace_first", 32'(first_k), 32'd250);
        check_eq("pace_last", 32'(last_k), 32'd1000);
        check_eq("pace_level", 32'(bus.hopper_level), 32'd196);
        check_eq("pace_low", 32'(bus.hopper_low), 32'd0);

        // hopper_stop held for 100 cycles at pace 200
        run_cycles(200, pulses, first_k, last_k, busy_cnt);
        check_eq("pre_hold_pulses", 32'(pulses), 32'd0);
        bus.hopper_stop = 1'b1;
        run_cycles(100, pulses, first_k, last_k, busy_cnt);
        check_eq("hold_pulses", 32'(pulses), 32'd0);
        bus.hopper_stop = 1'b0;
        run_cycles(50, pulses, first_k, last_k, busy_cnt);
        check_eq("release_pulses", 32'(pulses), 32'd1);
        check_eq("release_first", 32'(first_k), 32'd50);
        check_eq("release_level", 32'(bus.hopper_level), 32'd195);

        // Bottle change: 1000 busy cycles, then FEED and a pill 250 later
        pulse_bottle_full();
        check_eq("chg_busy_start", 32'(bus.conveyor_busy), 32'd1);
        check_eq("chg_not_feeding", 32'(bus.feeding), 32'd0);
        run_cycles(999, pulses, first_k, last_k, busy_cnt);
        check_eq("chg_busy_cnt", 32'(busy_cnt), 32'd999);
        check_eq("chg_pulses", 32'(pulses), 32'd0);
        run_cycles(1, pulses, first_k, last_k, busy_cnt);
        check_eq("chg_end_busy", 32'(busy_cnt), 32'd0);
        check_eq("chg_end_feeding", 32'(bus.feeding), 32'd1);
        run_cycles(250, pulses, first_k, last_k, busy_cnt);
        check_eq("post_chg_pulses", 32'(pulses), 32'd1);
        check_eq("post_chg_first", 32'(first_k), 32'd250);
        check_eq("post_chg_level", 32'(bus.hopper_level), 32'd194);

        // Conveyor jam during CHANGE
        pulse_bottle_full();
        run_cycles(10, pulses, first_k, last_k, busy_cnt);
        bus.conveyor_stop = 1'b1;
        @(negedge clk_1khz);
        check_eq("jam_fault", 32'(bus.fault), 32'd1);
        check_eq("jam_code", 32'(bus.fault_code), 32'd2);
        check_eq("jam_busy", 32'(bus.conveyor_busy), 32'd0);
        press_clr();
        check_eq("jam_clr_ignored", 32'(bus.fault), 32'd1);
        check_eq("jam_code_held", 32'(bus.fault_code), 32'd2);
        bus.conveyor_stop = 1'b0;
        bus.run_en        = 1'b0;
        run_cycles(5, pulses, first_k, last_k, busy_cnt);
        check_eq("jam_needs_edge", 32'(bus.fault), 32'd1);
        press_clr();
        check_eq("jam_cleared", 32'(bus.fault), 32'd0);
        check_eq("jam_code_clr", 32'(bus.fault_code), 32'd0);
        check_eq("jam_idle", 32'(bus.feeding), 32'd0);

        // estop together with bottle_full; refills saturate during FAULT
        bus.run_en = 1'b1;
        run_cycles(10, pulses, first_k, last_k, busy_cnt);
        check_eq("estop_pre_feed", 32'(bus.feeding), 32'd1);
        bus.estop = 1'b1;
        pulse_bottle_full();
        check_eq("estop_fault", 32'(bus.fault), 32'd1);
        check_eq("estop_code", 32'(bus.fault_code), 32'd1);
        check_eq("estop_no_chg", 32'(bus.conveyor_busy), 32'd0);
        run_cycles(20, pulses, first_k, last_k, busy_cnt);
        check_eq("estop_no_busy", 32'(busy_cnt), 32'd0);
        check_eq("estop_level", 32'(bus.hopper_level), 32'd194);
        press_add();
        check_eq("refill_sat1", 32'(bus.hopper_level), 32'd200);
        press_add();
        check_eq("refill_sat2", 32'(bus.hopper_level), 32'd200);
        press_clr();
        check_eq("estop_clr_ignored", 32'(bus.fault), 32'd1);
        bus.estop  = 1'b0;
        bus.run_en = 1'b0;
        press_clr();
        check_eq("estop_cleared", 32'(bus.fault), 32'd0);
        check_eq("estop_code_clr", 32'(bus.fault_code), 32'd0);

        // Drain the hopper, stall, then starvation fault
        bus.run_en = 1'b1;
        @(negedge clk_1khz);
        run_cycles(50000, pulses, first_k, last_k, busy_cnt);
        check_eq("drain_pulses", 32'(pulses), 32'd200);
        check_eq("drain_level", 32'(bus.hopper_level), 32'd0);
        check_eq("drain_low", 32'(bus.hopper_low), 32'd1);
        run_cycles(249, pulses, first_k, last_k, busy_cnt);
        check_eq("pre_stall_feed", 32'(bus.feeding), 32'd1);
        run_cycles(1, pulses, first_k, last_k, busy_cnt);
        check_eq("stall_no_pulse", 32'(pulses), 32'd0);
        check_eq("stall_feeding", 32'(bus.feeding), 32'd0);
        run_cycles(2999, pulses, first_k, last_k, busy_cnt);
        check_eq("stall_pre_fault", 32'(bus.fault), 32'd0);
        run_cycles(1, pulses, first_k, last_k, busy_cnt);
        check_eq("starve_fault", 32'(bus.fault), 32'd1);
        check_eq("starve_code", 32'(bus.fault_code), 32'd3);
        press_add();
        check_eq("starve_refill", 32'(bus.hopper_level), 32'd50);
        check_eq("starve_still_fault", 32'(bus.fault), 32'd1);
        bus.run_en = 1'b0;
        press_clr();
        check_eq("starve_cleared", 32'(bus.fault), 32'd0);
        check_eq("starve_code_clr", 32'(bus.fault_code), 32'd0);
        check_eq("starve_level", 32'(bus.hopper_level), 32'd50);

        // Reset mid-operation refills the hopper
        bus.run_en = 1'b1;
        run_cycles(300, pulses, first_k, last_k, busy_cnt);
        check_eq("mid_level", 32'(bus.hopper_level), 32'd49);
        switch_clr = 1'b0;
        #1;
        check_eq("mid_rst_level", 32'(bus.hopper_level), 32'd200);
        check_eq("mid_rst_feeding", 32'(bus.feeding), 32'd0);
        bus.run_en = 1'b0;
        @(negedge clk_1khz);
        switch_clr = 1'b1;
        @(negedge clk_1khz);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
